recording_channel: RTL and testbench
====================================

Name: recording_channel

Overview:
- Single-clock capture channel in the ADC clock domain of the rangefinder.
- A start pulse arms the channel and begins writing 8-bit ADC samples into an internal FIFO every clock.
- A stop (echo) pulse latches an absolute timestamp and ends recording after a programmable delay; stop_recording aborts without an echo.
- After recording ends, a downstream reader drains the FIFO word by word.

Parameters:
- DATA_W, 8, ADC sample width.
- DEPTH, 256, FIFO depth in words; must be a power of 2.
- CNT_W, 9, width of fill counts, equal to log2(DEPTH)+1.
- TS_W, 13, timestamp/abs_counter width.
- DLY_W, 8, stop_delay width.

Ports:
- clk  in  1  ADC-domain clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset). Also clears the FIFO.
- fifo_d  in  DATA_W  sample to record.
- start_pulse  in  1  one-cycle arm/start.
- stop_pulse  in  1  one-cycle echo-detected stop.
- stop_recording  in  1  one-cycle forced stop with no echo.
- stop_delay  in  DLY_W  clocks to keep recording after stop_pulse.
- abs_counter  in  TS_W  free-running timestamp.
- fifo_read_request  in  1  pop one word.
- echo_pulse_detected  out  1  recording ended by stop_pulse.
- sample_length  out  CNT_W  words stored when recording ended.
- fifo_usdw  out  CNT_W  live FIFO occupancy.
- fifo_q  out  DATA_W  read data.
- timestamp  out  TS_W  abs_counter at the stop_pulse cycle.

Behaviour:
- Reset values: state IDLE, FIFO empty, all outputs 0.
- States:
  - IDLE: no writes.
  - RECORD: writes fifo_d every cycle.
  - STOP_WAIT: writes every cycle while a delay counter runs.
  - DONE: no writes; readable.
- start_pulse in any state flushes the FIFO, clears echo_pulse_detected, sample_length and timestamp, and enters RECORD on the next edge.
- start_pulse has priority over every other input in the same cycle.
- RECORD, stop_pulse sampled:
  - That cycle's sample is written.
  - timestamp <= abs_counter; echo_pulse_detected <= 1.
  - If stop_delay == 0, go to DONE; otherwise load the counter with stop_delay and go to STOP_WAIT.
- STOP_WAIT: writes exactly stop_delay further samples, then enters DONE. Further stop_pulse is ignored.
- stop_recording:
  - In RECORD: that cycle's sample is written, then DONE with echo_pulse_detected = 0 and timestamp = 0.
  - In STOP_WAIT: DONE immediately; echo and timestamp are kept.
- stop_pulse and stop_recording in the same RECORD cycle: stop_pulse wins.
- stop_pulse and stop_recording in IDLE or DONE are ignored.
- Full buffer: writing continues, and each write discards the oldest word, so the FIFO holds the most recent DEPTH samples. fifo_usdw saturates at DEPTH.
- On entry to DONE, sample_length <= occupancy including the final write. sample_length holds until the next start or reset.
- Reads:
  - Honoured only in IDLE and DONE with FIFO non-empty.
  - fifo_q is registered and valid one clock after the request edge; it holds its value otherwise.
  - Read when empty: ignored, fifo_q unchanged.
  - Reads in RECORD and STOP_WAIT are ignored.
- fifo_usdw: decremented by each accepted read; updated on the edge after a write or read.
- Asynchronous reset mid-operation: returns to the reset state immediately.

Optional Feature:
- RECORDING_CHANNEL_OVERWRITE_EN
  - Defined: ring-overwrite on full, as described above.
  - Undefined: writes stop when the FIFO is full (first DEPTH samples retained). The state machine and delay counter still run, and fifo_usdw stays at DEPTH.

Decomposition:
- Package recording_channel_pkg: state enum (IDLE, RECORD, STOP_WAIT, DONE) and the DEPTH/width localparams.
- Sub-module rc_fifo: synchronous RAM FIFO.
  - Ports: clk, reset, flush, wr, rd, din, dout, usedw, full, empty.
  - Supports overwrite-on-full.
- The recording_channel top holds the FSM, the delay counter and the output registers.

Test Plan:
1. Reset low for 2 clocks → all outputs 0, fifo_usdw = 0; reads give no change in fifo_q.
2. fifo_d ramp (+1 per clock), start, stop_pulse 10 clocks after start, stop_delay = 4 → 10 + 4 = 14 writes, sample_length = 14, echo_pulse_detected = 1, timestamp = abs_counter at the stop cycle. 14 reads return 14 consecutive ramp values; fifo_usdw ends at 0.
3. Ramp, start, stop_pulse 400 clocks later, stop_delay = 64 → sample_length = 256; the first read equals the last written value − 255 (mod 256). Without the macro, the first read equals the first written value.
4. Start, then stop_recording after 20 clocks → sample_length = 20, echo_pulse_detected = 0, timestamp = 0.
5. stop_pulse with stop_delay = 0 → DONE next edge, sample_length = stored count. Reads in DONE while empty → no change.
6. start_pulse during DONE with 14 words stored → fifo_usdw = 0 and echo cleared on the next edge, then recording resumes. start and stop in the same cycle → start wins.

Source files
------------

// File: rtl/recording_channel_pkg.sv
// -----------------------------------------------------------------------------
// recording_channel_pkg
// Shared definitions for the rangefinder recording channel: default widths,
// FIFO depth, the channel state encoding and the overwrite-on-full selection.
//
// Configuration macro: RECORDING_CHANNEL_OVERWRITE_EN
//   defined   -> a full FIFO keeps accepting samples and drops the oldest word
//   undefined -> a full FIFO ignores further samples (first DEPTH kept)
// -----------------------------------------------------------------------------
package recording_channel_pkg;

   localparam int RC_DATA_W = 8;
   localparam int RC_DEPTH  = 256;
   localparam int RC_CNT_W  = 9;
   localparam int RC_TS_W   = 13;
   localparam int RC_DLY_W  = 8;

`ifdef RECORDING_CHANNEL_OVERWRITE_EN
   localparam bit RC_OVERWRITE_EN = 1'b1;
`else
   localparam bit RC_OVERWRITE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RECORD    = 2'd1,
      STOP_WAIT = 2'd2,
      DONE      = 2'd3
   } rc_state_e;

endpackage

// File: rtl/rc_fifo.sv
// -----------------------------------------------------------------------------
// rc_fifo
// Synchronous RAM FIFO with registered read data and optional overwrite of the
// oldest word when a write arrives while full.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset; empties the FIFO, clears dout
//   flush  : synchronous empty (pointers and count); dout is kept
//   wr     : write din this cycle
//   rd     : pop one word into dout this cycle (ignored when empty)
//   din    : write data
//   dout   : registered read data, holds between accepted reads
//   usedw  : occupancy, 0..DEPTH
//   full   : usedw == DEPTH
//   empty  : usedw == 0
// -----------------------------------------------------------------------------
module rc_fifo #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 256,
   parameter int CNT_W     = 9,
   parameter bit OVERWRITE = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              wr,
   input  logic              rd,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [CNT_W-1:0]  usedw,
   output logic              full,
   output logic              empty
);

   localparam int ADDR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_r;
   logic [ADDR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0]  usedw_r;
   logic [DATA_W-1:0] dout_r;

   logic              full_s;
   logic              empty_s;
   logic              wr_ok_s;
   logic              rd_ok_s;
   logic              drop_s;
   logic              inc_s;
   logic [CNT_W-1:0]  usedw_next_s;

   assign full_s  = (usedw_r == CNT_W'(DEPTH));
   assign empty_s = (usedw_r == {CNT_W{1'b0}});

   // Accept/drop decisions and the next occupancy value.
   always_comb begin
      wr_ok_s      = wr && (!full_s || OVERWRITE);
      rd_ok_s      = rd && !empty_s;
      // A write into a full FIFO with no pop in the same cycle evicts the oldest word.
      drop_s       = wr_ok_s && full_s && !rd_ok_s;
      inc_s        = wr_ok_s && !drop_s;
      usedw_next_s = usedw_r;
      case ({inc_s, rd_ok_s})
         2'b10:   usedw_next_s = usedw_r + CNT_W'(1);
         2'b01:   usedw_next_s = usedw_r - CNT_W'(1);
         default: usedw_next_s = usedw_r;
      endcase
   end

   // Sample storage; RAM contents are not reset.
   always_ff @(posedge clk) begin
      if (wr_ok_s && !flush) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers, occupancy and registered read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {ADDR_W{1'b0}};
         rd_ptr_r <= {ADDR_W{1'b0}};
         usedw_r  <= {CNT_W{1'b0}};
         dout_r   <= {DATA_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {ADDR_W{1'b0}};
         rd_ptr_r <= {ADDR_W{1'b0}};
         usedw_r  <= {CNT_W{1'b0}};
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
         end
         if (rd_ok_s || drop_s) begin
            rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
         end
         if (rd_ok_s) begin
            dout_r <= mem_r[rd_ptr_r];
         end
         usedw_r <= usedw_next_s;
      end
   end

   assign dout  = dout_r;
   assign usedw = usedw_r;
   assign full  = full_s;
   assign empty = empty_s;

endmodule

// File: rtl/recording_channel.sv
// -----------------------------------------------------------------------------
// recording_channel
// Capture channel in the ADC clock domain. start_pulse arms recording of one
// sample per clock into rc_fifo; stop_pulse (echo) stamps abs_counter and ends
// recording stop_delay clocks later; stop_recording aborts. Once recording has
// ended the FIFO is drained one word per fifo_read_request.
//
// Configuration macro: RECORDING_CHANNEL_OVERWRITE_EN (see recording_channel_pkg)
//
// Ports:
//   clk                 : ADC-domain clock, rising edge
//   reset               : asynchronous active-low reset, also empties the FIFO
//   fifo_d              : sample to record
//   start_pulse         : arm/restart; flushes FIFO and clears result registers
//   stop_pulse          : echo detected, stamps timestamp
//   stop_recording      : forced stop without echo
//   stop_delay          : extra samples recorded after stop_pulse
//   abs_counter         : free-running timestamp source
//   fifo_read_request   : pop one word (IDLE/DONE only)
//   echo_pulse_detected : recording ended by stop_pulse
//   sample_length       : words stored when recording ended
//   fifo_usdw           : live FIFO occupancy
//   fifo_q              : registered read data
//   timestamp           : abs_counter captured on the stop_pulse cycle
// -----------------------------------------------------------------------------
module recording_channel
   import recording_channel_pkg::*;
#(
   parameter int DATA_W = RC_DATA_W,
   parameter int DEPTH  = RC_DEPTH,
   parameter int CNT_W  = RC_CNT_W,
   parameter int TS_W   = RC_TS_W,
   parameter int DLY_W  = RC_DLY_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] fifo_d,
   input  logic              start_pulse,
   input  logic              stop_pulse,
   input  logic              stop_recording,
   input  logic [DLY_W-1:0]  stop_delay,
   input  logic [TS_W-1:0]   abs_counter,
   input  logic              fifo_read_request,
   output logic              echo_pulse_detected,
   output logic [CNT_W-1:0]  sample_length,
   output logic [CNT_W-1:0]  fifo_usdw,
   output logic [DATA_W-1:0] fifo_q,
   output logic [TS_W-1:0]   timestamp
);

   rc_state_e         state_r;
   logic [DLY_W-1:0]  dly_cnt_r;
   logic              echo_r;
   logic [CNT_W-1:0]  length_r;
   logic [TS_W-1:0]   ts_r;

   logic              wr_s;
   logic              rd_s;
   logic              full_s;
   logic              empty_s;
   logic [CNT_W-1:0]  usedw_s;
   logic [CNT_W-1:0]  len_after_wr_s;

   // FIFO control and the occupancy the FIFO will have after this cycle's write.
   always_comb begin
      wr_s = 1'b0;
      rd_s = 1'b0;
      case (state_r)
         RECORD:    wr_s = !start_pulse;
         STOP_WAIT: wr_s = !start_pulse && !stop_recording;
         IDLE,
         DONE:      rd_s = !start_pulse && fifo_read_request && !empty_s;
         default:   wr_s = 1'b0;
      endcase
      // A full FIFO stays at DEPTH whether the write overwrote or was dropped.
      if (full_s) begin
         len_after_wr_s = CNT_W'(DEPTH);
      end else begin
         len_after_wr_s = usedw_s + CNT_W'(1);
      end
   end

   // Channel FSM, stop-delay counter and result registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         dly_cnt_r <= {DLY_W{1'b0}};
         echo_r    <= 1'b0;
         length_r  <= {CNT_W{1'b0}};
         ts_r      <= {TS_W{1'b0}};
      end else if (start_pulse) begin
         state_r   <= RECORD;
         dly_cnt_r <= {DLY_W{1'b0}};
         echo_r    <= 1'b0;
         length_r  <= {CNT_W{1'b0}};
         ts_r      <= {TS_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               state_r <= IDLE;
            end
            RECORD: begin
               if (stop_pulse) begin
                  ts_r   <= abs_counter;
                  echo_r <= 1'b1;
                  if (stop_delay == {DLY_W{1'b0}}) begin
                     state_r  <= DONE;
                     length_r <= len_after_wr_s;
                  end else begin
                     dly_cnt_r <= stop_delay;
                     state_r   <= STOP_WAIT;
                  end
               end else if (stop_recording) begin
                  state_r  <= DONE;
                  echo_r   <= 1'b0;
                  ts_r     <= {TS_W{1'b0}};
                  length_r <= len_after_wr_s;
               end
            end
            STOP_WAIT: begin
               // Abort here skips the current sample, so length is the stored count.
               if (stop_recording) begin
                  state_r   <= DONE;
                  dly_cnt_r <= {DLY_W{1'b0}};
                  length_r  <= usedw_s;
               end else if (dly_cnt_r == DLY_W'(1)) begin
                  state_r   <= DONE;
                  dly_cnt_r <= {DLY_W{1'b0}};
                  length_r  <= len_after_wr_s;
               end else begin
                  dly_cnt_r <= dly_cnt_r - DLY_W'(1);
               end
            end
            DONE: begin
               state_r <= DONE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   rc_fifo #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .CNT_W     (CNT_W),
      .OVERWRITE (RC_OVERWRITE_EN)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (start_pulse),
      .wr    (wr_s),
      .rd    (rd_s),
      .din   (fifo_d),
      .dout  (fifo_q),
      .usedw (usedw_s),
      .full  (full_s),
      .empty (empty_s)
   );

   assign fifo_usdw           = usedw_s;
   assign echo_pulse_detected = echo_r;
   assign sample_length       = length_r;
   assign timestamp           = ts_r;

endmodule

// File: tb/tb_recording_channel.sv
// -----------------------------------------------------------------------------
// tb_recording_channel
// Self-checking bench for recording_channel: a table of capture scenarios
// followed by hand-written sequences for restart, DONE timing and async reset.
// -----------------------------------------------------------------------------
module tb_recording_channel;

`ifdef RECORDING_CHANNEL_OVERWRITE_EN
   localparam bit OVR = 1'b1;
`else
   localparam bit OVR = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [7:0]  fifo_d;
   logic        start_pulse;
   logic        stop_pulse;
   logic        stop_recording;
   logic [7:0]  stop_delay;
   logic [12:0] abs_counter;
   logic        fifo_read_request;
   logic        echo_pulse_detected;
   logic [8:0]  sample_length;
   logic [8:0]  fifo_usdw;
   logic [7:0]  fifo_q;
   logic [12:0] timestamp;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   recording_channel dut (
      .clk                 (clk),
      .reset               (reset),
      .fifo_d              (fifo_d),
      .start_pulse         (start_pulse),
      .stop_pulse          (stop_pulse),
      .stop_recording      (stop_recording),
      .stop_delay          (stop_delay),
      .abs_counter         (abs_counter),
      .fifo_read_request   (fifo_read_request),
      .echo_pulse_detected (echo_pulse_detected),
      .sample_length       (sample_length),
      .fifo_usdw           (fifo_usdw),
      .fifo_q              (fifo_q),
      .timestamp           (timestamp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // kind: 0 = stop_pulse, 1 = stop_recording, 2 = both in the same cycle
   typedef struct {
      int n_stop;
      int kind;
      int delay;
      int exp_len;
      bit exp_echo;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // One clock: sample point is 1 time unit after the rising edge; the ramp and
   // timestamp inputs advance there too.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      fifo_d      = 8'(cyc);
      abs_counter = 13'(cyc);
   endtask

   initial begin
      logic [7:0]  first;
      logic [7:0]  e;
      logic [12:0] exp_ts;
      int          total;

      vecs[0] = '{n_stop: 10,  kind: 0, delay: 4,  exp_len: 14,  exp_echo: 1'b1};
      vecs[1] = '{n_stop: 400, kind: 0, delay: 64, exp_len: 256, exp_echo: 1'b1};
      vecs[2] = '{n_stop: 20,  kind: 1, delay: 0,  exp_len: 20,  exp_echo: 1'b0};
      vecs[3] = '{n_stop: 5,   kind: 0, delay: 0,  exp_len: 5,   exp_echo: 1'b1};
      vecs[4] = '{n_stop: 7,   kind: 2, delay: 2,  exp_len: 9,   exp_echo: 1'b1};
      vecs[5] = '{n_stop: 250, kind: 0, delay: 6,  exp_len: 256, exp_echo: 1'b1};

      reset             = 1'b0;
      fifo_d            = 8'd0;
      start_pulse       = 1'b0;
      stop_pulse        = 1'b0;
      stop_recording    = 1'b0;
      stop_delay        = 8'd0;
      abs_counter       = 13'd0;
      fifo_read_request = 1'b0;

      // ---- reset state ----
      repeat (2) step();
      chk("rst_echo",  32'(echo_pulse_detected), 32'd0);
      chk("rst_len",   32'(sample_length),       32'd0);
      chk("rst_usdw",  32'(fifo_usdw),           32'd0);
      chk("rst_q",     32'(fifo_q),              32'd0);
      chk("rst_ts",    32'(timestamp),           32'd0);
      reset = 1'b1;
      fifo_read_request = 1'b1;
      step();
      fifo_read_request = 1'b0;
      chk("idle_empty_rd_q",    32'(fifo_q),    32'd0);
      chk("idle_empty_rd_usdw", 32'(fifo_usdw), 32'd0);

      // ---- table-driven captures ----
      for (int v = 0; v < 6; v++) begin
         stop_delay  = 8'(vecs[v].delay);
         start_pulse = 1'b1;
         step();
         start_pulse = 1'b0;
         first = fifo_d;
         repeat (vecs[v].n_stop - 1) step();
         stop_pulse     = (vecs[v].kind != 1);
         stop_recording = (vecs[v].kind != 0);
         exp_ts         = (vecs[v].kind != 1) ? abs_counter : 13'd0;
         step();
         stop_pulse     = 1'b0;
         stop_recording = 1'b0;
         repeat (vecs[v].delay + 2) step();

         total = vecs[v].n_stop + ((vecs[v].kind != 1) ? vecs[v].delay : 0);
         chk($sformatf("v%0d_len", v),  32'(sample_length),       32'(vecs[v].exp_len));
         chk($sformatf("v%0d_echo", v), 32'(echo_pulse_detected), 32'(vecs[v].exp_echo));
         chk($sformatf("v%0d_ts", v),   32'(timestamp),           32'(exp_ts));
         chk($sformatf("v%0d_usdw", v), 32'(fifo_usdw),           32'(vecs[v].exp_len));

         e = first;
         if (OVR && total > 256) begin
            e = first + 8'(total - 256);
         end
         for (int i = 0; i < vecs[v].exp_len; i++) begin
            fifo_read_request = 1'b1;
            step();
            chk($sformatf("v%0d_rd%0d", v, i), 32'(fifo_q), 32'(8'(e + 8'(i))));
         end
         fifo_read_request = 1'b0;
         chk($sformatf("v%0d_drained", v),  32'(fifo_usdw),     32'd0);
         chk($sformatf("v%0d_len_hold", v), 32'(sample_length), 32'(vecs[v].exp_len));

         fifo_read_request = 1'b1;
         step();
         fifo_read_request = 1'b0;
         chk($sformatf("v%0d_empty_rd", v), 32'(fifo_q), 32'(8'(e + 8'(vecs[v].exp_len - 1))));
      end

      // ---- stop_delay = 0 reaches DONE on the stop edge ----
      stop_delay  = 8'd0;
      start_pulse = 1'b1;
      step();
      start_pulse = 1'b0;
      repeat (2) step();
      stop_pulse = 1'b1;
      step();
      stop_pulse = 1'b0;
      chk("d0_len_now",  32'(sample_length),       32'd3);
      chk("d0_echo_now", 32'(echo_pulse_detected), 32'd1);
      repeat (2) step();
      chk("d0_no_more_wr", 32'(fifo_usdw), 32'd3);

      // ---- restart from DONE with 14 stored, reads ignored while recording ----
      stop_delay  = 8'd4;
      start_pulse = 1'b1;
      step();
      start_pulse = 1'b0;
      repeat (9) step();
      stop_pulse = 1'b1;
      exp_ts     = abs_counter;
      step();
      stop_pulse = 1'b0;
      repeat (6) step();
      chk("rs_usdw14", 32'(fifo_usdw),     32'd14);
      chk("rs_len14",  32'(sample_length), 32'd14);
      chk("rs_ts",     32'(timestamp),     32'(exp_ts));
      start_pulse = 1'b1;
      step();
      start_pulse = 1'b0;
      chk("rs_flush_usdw", 32'(fifo_usdw),           32'd0);
      chk("rs_flush_echo", 32'(echo_pulse_detected), 32'd0);
      chk("rs_flush_len",  32'(sample_length),       32'd0);
      chk("rs_flush_ts",   32'(timestamp),           32'd0);
      fifo_read_request = 1'b1;
      repeat (3) step();
      fifo_read_request = 1'b0;
      chk("rec_rd_ignored", 32'(fifo_usdw), 32'd3);

      // start and stop together while recording: start wins
      start_pulse = 1'b1;
      stop_pulse  = 1'b1;
      step();
      start_pulse = 1'b0;
      stop_pulse  = 1'b0;
      chk("ss_usdw", 32'(fifo_usdw),           32'd0);
      chk("ss_echo", 32'(echo_pulse_detected), 32'd0);
      chk("ss_ts",   32'(timestamp),           32'd0);
      repeat (3) step();
      stop_recording = 1'b1;
      step();
      stop_recording = 1'b0;
      chk("ss_abort_len",  32'(sample_length),       32'd4);
      chk("ss_abort_echo", 32'(echo_pulse_detected), 32'd0);

      // ---- asynchronous reset in STOP_WAIT ----
      fifo_read_request = 1'b1;
      step();
      fifo_read_request = 1'b0;
      stop_delay  = 8'd10;
      start_pulse = 1'b1;
      step();
      start_pulse = 1'b0;
      repeat (2) step();
      stop_pulse = 1'b1;
      step();
      stop_pulse = 1'b0;
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_echo", 32'(echo_pulse_detected), 32'd0);
      chk("arst_ts",   32'(timestamp),           32'd0);
      chk("arst_usdw", 32'(fifo_usdw),           32'd0);
      chk("arst_len",  32'(sample_length),       32'd0);
      chk("arst_q",    32'(fifo_q),              32'd0);
      #1;
      reset = 1'b1;
      repeat (3) step();
      chk("arst_idle_no_wr", 32'(fifo_usdw), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
